// File: rtl/mesh_term_fifo_bank.sv
// Bank of independent show-ahead packet FIFOs, one per mesh edge terminal.
// Each channel tracks occupancy, overflow drops and sticky underflow.
module mesh_term_fifo_bank #(
  parameter int ROWS       = 4,
  parameter int COLUMS     = 4,
  parameter int pckg_sz    = 40,
  parameter int fifo_depth = 4,
  parameter int AF_LEVEL   = fifo_depth - 1,
  parameter int OVERWRITE  = 0
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  push        [ROWS*2+COLUMS*2],
  input  logic [pckg_sz-1:0]                    data_in     [ROWS*2+COLUMS*2],
  input  logic                                  pop         [ROWS*2+COLUMS*2],
  output logic                                  pndng       [ROWS*2+COLUMS*2],
  output logic [pckg_sz-1:0]                    data_out    [ROWS*2+COLUMS*2],
  output logic                                  full        [ROWS*2+COLUMS*2],
  output logic                                  almost_full [ROWS*2+COLUMS*2],
  output logic [$clog2(fifo_depth+1)-1:0]       count       [ROWS*2+COLUMS*2],
  output logic [15:0]                           drop_cnt    [ROWS*2+COLUMS*2],
  output logic                                  underflow   [ROWS*2+COLUMS*2]
);

  localparam int N  = ROWS*2 + COLUMS*2;
  localparam int CW = $clog2(fifo_depth+1);
  localparam int PW = (fifo_depth > 1) ? $clog2(fifo_depth) : 1;

  localparam logic [PW-1:0] LAST  = PW'(fifo_depth - 1);
  localparam logic [CW-1:0] DEPTH = CW'(fifo_depth);
  localparam logic [CW-1:0] AFL   = CW'(AF_LEVEL);

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  for (genvar g = 0; g < N; g++) begin : g_ch
    logic [pckg_sz-1:0] mem [fifo_depth];
    logic [PW-1:0]      rd_ptr;
    logic [PW-1:0]      wr_ptr;
    logic [CW-1:0]      cnt;
    logic [15:0]        drops;
    logic               uflow;
    logic               empty;
    logic               is_full;
    logic               pop_ok;
    logic               drop;
    logic               ovw;
    logic               wr_en;
    logic               rd_adv;

    always_comb begin
      empty   = (cnt == '0);
      is_full = (cnt == DEPTH);
      pop_ok  = pop[g] && !empty;
      drop    = push[g] && is_full && !pop[g];
      ovw     = drop && (OVERWRITE != 0);
      wr_en   = push[g] && (!is_full || pop[g] || ovw);
      rd_adv  = pop_ok || ovw;
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        cnt    <= '0;
        drops  <= '0;
        uflow  <= 1'b0;
      end else begin
        if (wr_en)
          wr_ptr <= nxt(wr_ptr);
        if (rd_adv)
          rd_ptr <= nxt(rd_ptr);
        if (wr_en && !rd_adv)
          cnt <= cnt + 1'b1;
        else if (rd_adv && !wr_en)
          cnt <= cnt - 1'b1;
        if (drop && (drops != 16'hFFFF))
          drops <= drops + 16'd1;
        if (pop[g] && empty)
          uflow <= 1'b1;
      end
    end

    // Storage is not cleared on reset; pointers define validity.
    always_ff @(posedge clk) begin
      if (!reset && wr_en)
        mem[wr_ptr] <= data_in[g];
    end

    assign pndng[g]       = !empty;
    assign full[g]        = is_full;
    assign almost_full[g] = (cnt >= AFL);
    assign count[g]       = cnt;
    assign drop_cnt[g]    = drops;
    assign underflow[g]   = uflow;
    assign data_out[g]    = mem[rd_ptr];
  end

endmodule

// File: doc/mesh_term_fifo_bank.md
# mesh_term_fifo_bank

Parametrised bank of per-terminal packet FIFOs sitting between the test driver and the mesh's terminal ports, one channel per edge terminal (2·ROWS + 2·COLUMS). Each channel buffers pckg_sz-bit packets and presents them to the mesh with a show-ahead pndng/data_out/pop handshake. It generalises the per-terminal signal bundle into a buffered, depth-configurable block with full/almost-full back-pressure, selectable overflow policy, and per-channel drop and underflow accounting.

## Interface
Parameters:
- ROWS, 4, mesh rows
- COLUMS, 4, mesh columns
- pckg_sz, 40, packet width in bits
- fifo_depth, 4, entries per channel; legal range ≥2, need not be a power of two
- AF_LEVEL, fifo_depth-1, almost_full threshold; legal range 1..fifo_depth
- OVERWRITE, 0, 0 = drop incoming packet when full, 1 = overwrite oldest entry when full
- Derived localparams: N = ROWS*2+COLUMS*2 channels; CW = $clog2(fifo_depth+1)

Ports (all per-channel signals are unpacked arrays [N]):
- clk  in  1  single clock, all state updates on rising edge
- reset  in  1  synchronous, active-high; clears every channel
- push[N]  in  1  driver writes data_in[i] this cycle
- data_in[N]  in  pckg_sz  packet to enqueue
- pop[N]  in  1  mesh consumes head of channel i this cycle
- pndng[N]  out  1  channel i non-empty
- data_out[N]  out  pckg_sz  head entry of channel i (show-ahead)
- full[N]  out  1  count == fifo_depth
- almost_full[N]  out  1  count ≥ AF_LEVEL
- count[N]  out  CW  current occupancy
- drop_cnt[N]  out  16  packets lost to overflow, saturates at 16'hFFFF
- underflow[N]  out  1  sticky: pop seen while empty

## Operation
- Channels fully independent; identical logic replicated N times.
- Per channel: storage mem[fifo_depth], rd_ptr, wr_ptr (wrap fifo_depth-1 → 0, explicit compare, not modulo-2^k), count register.
- Push, not full: mem[wr_ptr] ← data_in, wr_ptr++, count++.
- Pop, not empty: rd_ptr++, count--.
- Push and pop same cycle, 0 < count < fifo_depth: both performed, count unchanged.
- Push and pop, full: both performed, no drop, count stays fifo_depth (both modes).
- Push and pop, empty: push performed, pop ignored, underflow set; count → 1. No bypass.
- Pop while empty (with or without push): underflow ← 1, sticky until reset.
- Push while full, no pop, OVERWRITE=0: packet discarded, storage/pointers unchanged, drop_cnt++.
- Push while full, no pop, OVERWRITE=1: mem[wr_ptr] ← data_in, wr_ptr++, rd_ptr++ (oldest lost), count stays fifo_depth, drop_cnt++.
- drop_cnt saturates; no wrap.
- Flags pndng/full/almost_full are decoded from registered count; data_out = mem[rd_ptr].

## Timing
- Reset (sync, sampled at rising edge): next cycle all pointers/count = 0, pndng=0, full=0, almost_full=0 (AF_LEVEL≥1), drop_cnt=0, underflow=0; data_out content undefined but memory need not be cleared. Reset asserted mid-traffic discards all queued packets; push/pop in the reset cycle are ignored.
- Push at edge k → pndng and data_out valid after edge k (visible in cycle k+1). Latency 1.
- Pop at edge k → next entry on data_out in cycle k+1; pndng drops in k+1 if last entry.
- full/almost_full update one cycle after the causing push/pop; the driver must sample full combinationally before pushing and accept that a same-cycle push against full is handled by the overflow policy.
- No combinational path from push/pop to any output.

## Test plan
- Reset then push ch0 with 40'h00_0000_0001..4 (depth 4) → pndng[0]=1 one cycle after first push, full[0]=1 after 4th, count[0]=4, almost_full[0]=1 from count 3; pops return 1,2,3,4 in order, pndng[0]=0 after 4th pop.
- OVERWRITE=0, ch5 full with A,B,C,D, push E → drop_cnt[5]=1, pops return A,B,C,D; E never appears.
- OVERWRITE=1, same stimulus → drop_cnt[5]=1, pops return B,C,D,E.
- Ch3 full, push X with pop same cycle → head advances, count stays 4, drop_cnt[3]=0, X returned last; ch7 empty, push Y with pop → underflow[7]=1, count[7]=1, data_out[7]=Y next cycle.
- fifo_depth=5 (non-power-of-2): 12 push/pop interleaved cycles wrapping pointers twice → data order preserved, count never exceeds 5.
- All 16 channels loaded with 3 packets, reset asserted for one cycle mid-drain → next cycle every pndng=0, count=0, drop_cnt=0, underflow=0; subsequent push on ch15 appears after one cycle.
